// File: rtl/motion_bbox_extract.sv
// -----------------------------------------------------------------------------
// motion_bbox_extract
//
// Purpose:
//   Consumes the vsync/href/clken/bit stream of the 5x5 erosion stage and
//   tracks the column/row extent of surviving foreground pixels over each
//   frame. At the start of every new frame the previous frame's bounding box
//   and a "found" flag are published for the box-overlay/draw stage.
//
// Optional feature macro: BOX_PIX_CNT_EN
//   Defined   : a 19-bit foreground pixel counter is built and exposed on
//               box_pix_cnt. box_found requires count >= MIN_PIX_CNT, which
//               rejects residual speckle.
//   Undefined : no counter and no box_pix_cnt port. box_found is set when
//               any foreground pixel was seen.
//
// Ports:
//   clk              in   pixel clock
//   rst_n            in   synchronous active-low reset
//   erosion_vsync    in   frame sync, rising edge = frame start
//   erosion_href     in   line valid
//   erosion_clken    in   pixel valid
//   erosion_img_Bit  in   eroded pixel (1 = foreground)
//   box_valid        out  one-cycle pulse, box outputs just updated
//   box_found        out  previous frame contained a qualifying object
//   box_x_min/max    out  leftmost/rightmost foreground column
//   box_y_min/max    out  top/bottom foreground row
//   box_pix_cnt      out  foreground pixel count (BOX_PIX_CNT_EN only)
//
// Publish timing: vsync first sampled high at edge N -> snapshot and
// accumulator clear at edge N, outputs updated with box_valid high after
// edge N+1, box_valid low again after edge N+2.
// -----------------------------------------------------------------------------
module motion_bbox_extract #(
  parameter logic [9:0]  IMG_HDISP   = 10'd640,
  parameter logic [9:0]  IMG_VDISP   = 10'd480,
  parameter logic [18:0] MIN_PIX_CNT = 19'd16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        erosion_vsync,
  input  logic        erosion_href,
  input  logic        erosion_clken,
  input  logic        erosion_img_Bit,
  output logic        box_valid,
  output logic        box_found,
  output logic [9:0]  box_x_min,
  output logic [9:0]  box_x_max,
  output logic [9:0]  box_y_min,
`ifdef BOX_PIX_CNT_EN
  output logic [9:0]  box_y_max,
  output logic [18:0] box_pix_cnt
`else
  output logic [9:0]  box_y_max
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    LATCH = 2'd2
  } state_t;

  state_t state;

  // ---------------------------------------------------------------------------
  // Sync edge detection
  // ---------------------------------------------------------------------------
  logic vsync_d;
  logic href_d;
  logic vs_rise;
  logic hs_fall;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vsync_d <= 1'b0;
      href_d  <= 1'b0;
    end else begin
      vsync_d <= erosion_vsync;
      href_d  <= erosion_href;
    end
  end

  assign vs_rise = erosion_vsync & ~vsync_d;
  assign hs_fall = ~erosion_href & href_d;

  // ---------------------------------------------------------------------------
  // Pixel position counters
  // ---------------------------------------------------------------------------
  // The counters saturate at the last active column/row. A separate overflow
  // flag marks that the saturated position has already been consumed, so any
  // pixel beyond the active area is ignored instead of being folded onto the
  // last column/row.
  logic [9:0] x;
  logic [9:0] y;
  logic       x_ovf;
  logic       y_ovf;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x     <= 10'd0;
      x_ovf <= 1'b0;
    end else if (!erosion_href) begin
      x     <= 10'd0;
      x_ovf <= 1'b0;
    end else if (erosion_clken && !x_ovf) begin
      if (x == IMG_HDISP - 10'd1) begin
        x_ovf <= 1'b1;
      end else begin
        x <= x + 10'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y     <= 10'd0;
      y_ovf <= 1'b0;
    end else if (vs_rise) begin
      y     <= 10'd0;
      y_ovf <= 1'b0;
    end else if (hs_fall && !y_ovf) begin
      if (y == IMG_VDISP - 10'd1) begin
        y_ovf <= 1'b1;
      end else begin
        y <= y + 10'd1;
      end
    end
  end

  // A pixel coinciding with vs_rise is dropped: the frame boundary wins.
  logic fg_hit;
  assign fg_hit = erosion_clken & erosion_href & erosion_img_Bit &
                  ~x_ovf & ~y_ovf & ~vs_rise;

  // ---------------------------------------------------------------------------
  // Per-frame accumulators
  // ---------------------------------------------------------------------------
  logic [9:0] acc_xmin;
  logic [9:0] acc_xmax;
  logic [9:0] acc_ymin;
  logic [9:0] acc_ymax;
  logic       acc_any;

  always_ff @(posedge clk) begin
    if (!rst_n || vs_rise) begin
      acc_xmin <= IMG_HDISP - 10'd1;
      acc_xmax <= 10'd0;
      acc_ymin <= IMG_VDISP - 10'd1;
      acc_ymax <= 10'd0;
      acc_any  <= 1'b0;
    end else if (fg_hit) begin
      if (x < acc_xmin) acc_xmin <= x;
      if (x > acc_xmax) acc_xmax <= x;
      if (y < acc_ymin) acc_ymin <= y;
      if (y > acc_ymax) acc_ymax <= y;
      acc_any <= 1'b1;
    end
  end

  // Qualification of the frame being closed, evaluated from the accumulators
  // as they stand at vs_rise.
  logic frame_found;

`ifdef BOX_PIX_CNT_EN
  logic [18:0] acc_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || vs_rise) begin
      acc_cnt <= 19'd0;
    end else if (fg_hit && (acc_cnt != {19{1'b1}})) begin
      acc_cnt <= acc_cnt + 19'd1;
    end
  end

  assign frame_found = (acc_cnt >= MIN_PIX_CNT);
`else
  logic unused_min_pix_cnt;
  assign unused_min_pix_cnt = ^MIN_PIX_CNT;
  assign frame_found        = acc_any;
`endif

  // ---------------------------------------------------------------------------
  // Snapshot at frame end
  // ---------------------------------------------------------------------------
  // Taken on the same edge that clears the accumulators, so the first pixel
  // of the new frame lands in a clean accumulator. An empty frame snapshots
  // all-zero coordinates.
  logic [9:0] snap_xmin;
  logic [9:0] snap_xmax;
  logic [9:0] snap_ymin;
  logic [9:0] snap_ymax;
  logic       snap_found;
`ifdef BOX_PIX_CNT_EN
  logic [18:0] snap_cnt;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      snap_xmin  <= 10'd0;
      snap_xmax  <= 10'd0;
      snap_ymin  <= 10'd0;
      snap_ymax  <= 10'd0;
      snap_found <= 1'b0;
`ifdef BOX_PIX_CNT_EN
      snap_cnt   <= 19'd0;
`endif
    end else if (vs_rise) begin
      snap_xmin  <= acc_any ? acc_xmin : 10'd0;
      snap_xmax  <= acc_any ? acc_xmax : 10'd0;
      snap_ymin  <= acc_any ? acc_ymin : 10'd0;
      snap_ymax  <= acc_any ? acc_ymax : 10'd0;
      snap_found <= frame_found;
`ifdef BOX_PIX_CNT_EN
      snap_cnt   <= acc_cnt;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Publish FSM with registered outputs
  // ---------------------------------------------------------------------------
  // IDLE discards the partial frame seen since reset. A vs_rise while in
  // LATCH re-arms LATCH: the snapshot register already holds the newer frame
  // while the older one is being published this cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      box_valid <= 1'b0;
      box_found <= 1'b0;
      box_x_min <= 10'd0;
      box_x_max <= 10'd0;
      box_y_min <= 10'd0;
      box_y_max <= 10'd0;
`ifdef BOX_PIX_CNT_EN
      box_pix_cnt <= 19'd0;
`endif
    end else begin
      box_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (vs_rise) state <= ACCUM;
        end
        ACCUM: begin
          if (vs_rise) state <= LATCH;
        end
        LATCH: begin
          box_valid <= 1'b1;
          box_found <= snap_found;
          box_x_min <= snap_xmin;
          box_x_max <= snap_xmax;
          box_y_min <= snap_ymin;
          box_y_max <= snap_ymax;
`ifdef BOX_PIX_CNT_EN
          box_pix_cnt <= snap_cnt;
`endif
          state <= vs_rise ? LATCH : ACCUM;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_motion_bbox_extract.sv
module tb_motion_bbox_extract;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        erosion_vsync;
  logic        erosion_href;
  logic        erosion_clken;
  logic        erosion_img_Bit;
  logic        box_valid;
  logic        box_found;
  logic [9:0]  box_x_min;
  logic [9:0]  box_x_max;
  logic [9:0]  box_y_min;
  logic [9:0]  box_y_max;
  logic [18:0] box_pix_cnt;

  int vec_cnt = 0;
  int err_cnt = 0;

`ifdef BOX_PIX_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  motion_bbox_extract dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .erosion_vsync   (erosion_vsync),
    .erosion_href    (erosion_href),
    .erosion_clken   (erosion_clken),
    .erosion_img_Bit (erosion_img_Bit),
    .box_valid       (box_valid),
    .box_found       (box_found),
    .box_x_min       (box_x_min),
    .box_x_max       (box_x_max),
    .box_y_min       (box_y_min),
`ifdef BOX_PIX_CNT_EN
    .box_y_max       (box_y_max),
    .box_pix_cnt     (box_pix_cnt)
`else
    .box_y_max       (box_y_max)
`endif
  );

`ifndef BOX_PIX_CNT_EN
  assign box_pix_cnt = 19'd0;
`endif

  always #5 clk = ~clk;

  // Captured values of a publish window.
  int          npulse;
  int          first_idx;
  logic        c_found;
  logic [39:0] c_box;
  logic [18:0] c_cnt;

  // Drives one frame of lines. Rows touched by a blob are len_busy pixels
  // long, other rows are a single background pixel. Blob with x0>x1 is empty.
  task automatic send_frame(input int nrows, input int len_busy,
                            input int ax0, input int ax1, input int ay0, input int ay1,
                            input int bx0, input int bx1, input int by0, input int by1);
    for (int r = 0; r < nrows; r++) begin
      bit busy;
      int len;
      busy = ((r >= ay0) && (r <= ay1) && (ax0 <= ax1)) ||
             ((r >= by0) && (r <= by1) && (bx0 <= bx1));
      len  = busy ? len_busy : 1;
      for (int c = 0; c < len; c++) begin
        @(negedge clk);
        erosion_href    = 1'b1;
        erosion_clken   = 1'b1;
        erosion_img_Bit = ((r >= ay0) && (r <= ay1) && (c >= ax0) && (c <= ax1)) ||
                          ((r >= by0) && (r <= by1) && (c >= bx0) && (c <= bx1));
      end
      @(negedge clk);
      erosion_href    = 1'b0;
      erosion_clken   = 1'b0;
      erosion_img_Bit = 1'b0;
    end
    @(negedge clk);
  endtask

  // Raises vsync for two cycles and watches box_valid for six cycles.
  task automatic pulse_vsync();
    npulse    = 0;
    first_idx = -1;
    @(negedge clk);
    erosion_vsync = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (box_valid === 1'b1) begin
        if (npulse == 0) begin
          first_idx = i;
          c_found   = box_found;
          c_box     = {box_x_min, box_x_max, box_y_min, box_y_max};
          c_cnt     = box_pix_cnt;
        end
        npulse++;
      end
      if (i == 1) erosion_vsync = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    erosion_vsync = 1'b0; erosion_href = 1'b0;
    erosion_clken = 1'b0; erosion_img_Bit = 1'b0;
    do_reset();
    vec_cnt++;
    if ({box_valid, box_found} !== 2'b00) begin
      err_cnt++;
      $display("FAIL reset_flags: got %b expected 00", {box_valid, box_found});
    end
    vec_cnt++;
    if ({box_x_min, box_x_max, box_y_min, box_y_max} !== 40'd0) begin
      err_cnt++;
      $display("FAIL reset_box: got %h expected 0", {box_x_min, box_x_max, box_y_min, box_y_max});
    end
    vec_cnt++;
    if (box_pix_cnt !== 19'd0) begin
      err_cnt++;
      $display("FAIL reset_cnt: got %0d expected 0", box_pix_cnt);
    end
    $display("reset: valid=%b found=%b", box_valid, box_found);
  endtask

  task automatic test_empty_frames();
    pulse_vsync();
    vec_cnt++;
    if (npulse !== 0) begin
      err_cnt++;
      $display("FAIL empty_first_vsync: got %0d pulses expected 0", npulse);
    end
    send_frame(4, 1, 1, 0, 1, 0, 1, 0, 1, 0);
    pulse_vsync();
    vec_cnt++;
    if (npulse !== 1 || first_idx !== 1) begin
      err_cnt++;
      $display("FAIL empty_pulse: got %0d pulses at %0d expected 1 at 1", npulse, first_idx);
    end
    vec_cnt++;
    if ({c_found, c_box} !== 41'd0) begin
      err_cnt++;
      $display("FAIL empty_box: got found=%b box=%h expected 0/0", c_found, c_box);
    end
    $display("empty frame: pulses=%0d found=%b box=%h", npulse, c_found, c_box);
  endtask

  task automatic test_block();
    send_frame(60, 120, 100, 119, 50, 59, 1, 0, 1, 0);
    pulse_vsync();
    vec_cnt++;
    if (npulse !== 1 || first_idx !== 1) begin
      err_cnt++;
      $display("FAIL block_pulse: got %0d pulses at %0d expected 1 at 1", npulse, first_idx);
    end
    vec_cnt++;
    if (c_box !== {10'd100, 10'd119, 10'd50, 10'd59} || c_found !== 1'b1) begin
      err_cnt++;
      $display("FAIL block_box: got found=%b %0d/%0d/%0d/%0d expected 1 100/119/50/59",
               c_found, c_box[39:30], c_box[29:20], c_box[19:10], c_box[9:0]);
    end
    if (CNT_EN) begin
      vec_cnt++;
      if (c_cnt !== 19'd200) begin
        err_cnt++;
        $display("FAIL block_cnt: got %0d expected 200", c_cnt);
      end
    end
    @(negedge clk);
    vec_cnt++;
    if (box_valid !== 1'b0 || box_x_min !== 10'd100 || box_y_max !== 10'd59) begin
      err_cnt++;
      $display("FAIL block_hold: got valid=%b xmin=%0d ymax=%0d expected 0/100/59",
               box_valid, box_x_min, box_y_max);
    end
    $display("block: found=%b box=%0d/%0d/%0d/%0d cnt=%0d", c_found,
             c_box[39:30], c_box[29:20], c_box[19:10], c_box[9:0], c_cnt);
  endtask

  task automatic test_corner_pixels();
    send_frame(1, 1, 0, 0, 0, 0, 1, 0, 1, 0);
    pulse_vsync();
    vec_cnt++;
    if (npulse !== 1 || c_box !== 40'd0 || c_found !== !CNT_EN) begin
      err_cnt++;
      $display("FAIL corner_00: got pulses=%0d found=%b box=%h expected 1/%b/0",
               npulse, c_found, c_box, !CNT_EN);
    end
    if (CNT_EN) begin
      vec_cnt++;
      if (c_cnt !== 19'd1) begin
        err_cnt++;
        $display("FAIL corner_00_cnt: got %0d expected 1", c_cnt);
      end
    end
    $display("corner (0,0): found=%b box=%h", c_found, c_box);
    send_frame(480, 640, 639, 639, 479, 479, 1, 0, 1, 0);
    pulse_vsync();
    vec_cnt++;
    if (npulse !== 1 || c_box !== {10'd639, 10'd639, 10'd479, 10'd479} || c_found !== !CNT_EN) begin
      err_cnt++;
      $display("FAIL corner_max: got pulses=%0d found=%b %0d/%0d/%0d/%0d expected 1/%b 639/639/479/479",
               npulse, c_found, c_box[39:30], c_box[29:20], c_box[19:10], c_box[9:0], !CNT_EN);
    end
    $display("corner (639,479): found=%b box=%0d/%0d/%0d/%0d", c_found,
             c_box[39:30], c_box[29:20], c_box[19:10], c_box[9:0]);
  endtask

  task automatic test_two_blobs();
    send_frame(403, 604, 10, 14, 5, 7, 600, 603, 400, 402);
    pulse_vsync();
    vec_cnt++;
    if (npulse !== 1 || c_box !== {10'd10, 10'd603, 10'd5, 10'd402} || c_found !== 1'b1) begin
      err_cnt++;
      $display("FAIL two_blobs: got pulses=%0d found=%b %0d/%0d/%0d/%0d expected 1/1 10/603/5/402",
               npulse, c_found, c_box[39:30], c_box[29:20], c_box[19:10], c_box[9:0]);
    end
    if (CNT_EN) begin
      vec_cnt++;
      if (c_cnt !== 19'd27) begin
        err_cnt++;
        $display("FAIL two_blobs_cnt: got %0d expected 27", c_cnt);
      end
    end
    $display("two blobs: found=%b box=%0d/%0d/%0d/%0d", c_found,
             c_box[39:30], c_box[29:20], c_box[19:10], c_box[9:0]);
  endtask

  task automatic test_overflow_line();
    send_frame(1, 650, 0, 649, 0, 0, 1, 0, 1, 0);
    pulse_vsync();
    vec_cnt++;
    if (npulse !== 1 || c_box !== {10'd0, 10'd639, 10'd0, 10'd0} || c_found !== 1'b1) begin
      err_cnt++;
      $display("FAIL overflow_line: got pulses=%0d found=%b %0d/%0d/%0d/%0d expected 1/1 0/639/0/0",
               npulse, c_found, c_box[39:30], c_box[29:20], c_box[19:10], c_box[9:0]);
    end
    if (CNT_EN) begin
      vec_cnt++;
      if (c_cnt !== 19'd640) begin
        err_cnt++;
        $display("FAIL overflow_cnt: got %0d expected 640", c_cnt);
      end
    end
    $display("overflow line: box=%0d/%0d/%0d/%0d", c_box[39:30], c_box[29:20],
             c_box[19:10], c_box[9:0]);
  endtask

  task automatic test_midframe_reset();
    send_frame(4, 8, 2, 5, 0, 3, 1, 0, 1, 0);
    do_reset();
    vec_cnt++;
    if (box_x_max !== 10'd0 || box_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL midreset_clear: got xmax=%0d valid=%b expected 0/0", box_x_max, box_valid);
    end
    pulse_vsync();
    vec_cnt++;
    if (npulse !== 0) begin
      err_cnt++;
      $display("FAIL midreset_no_publish: got %0d pulses expected 0", npulse);
    end
    send_frame(6, 40, 30, 34, 2, 5, 1, 0, 1, 0);
    pulse_vsync();
    vec_cnt++;
    if (npulse !== 1 || c_box !== {10'd30, 10'd34, 10'd2, 10'd5} || c_found !== 1'b1) begin
      err_cnt++;
      $display("FAIL midreset_blob: got pulses=%0d found=%b %0d/%0d/%0d/%0d expected 1/1 30/34/2/5",
               npulse, c_found, c_box[39:30], c_box[29:20], c_box[19:10], c_box[9:0]);
    end
    if (CNT_EN) begin
      vec_cnt++;
      if (c_cnt !== 19'd20) begin
        err_cnt++;
        $display("FAIL midreset_cnt: got %0d expected 20", c_cnt);
      end
    end
    $display("after mid-frame reset: box=%0d/%0d/%0d/%0d", c_box[39:30], c_box[29:20],
             c_box[19:10], c_box[9:0]);
  endtask

  initial begin
    test_reset();
    test_empty_frames();
    test_block();
    test_corner_pixels();
    test_two_blobs();
    test_overflow_line();
    test_midframe_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
